// File: rtl/decoder_2_to_4.sv
// Registered 2-to-4 one-hot decoder with optional output polarity inversion.
// Defining DECODER_2_TO_4_INPUT_REG_EN adds an input register stage (2-cycle latency).
module decoder_2_to_4 #(
  parameter int OUT_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] in,
  output logic [3:0] out
);

  localparam logic [3:0] POL_MASK = (OUT_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  // Unknown select codes fall through to the default and decode to all-deasserted.
  function automatic logic [3:0] decode(input logic en, input logic [1:0] sel);
    logic [3:0] res;
    res = 4'b0000;
    if (en) begin
      case (sel)
        2'b00:   res = 4'b0001;
        2'b01:   res = 4'b0010;
        2'b10:   res = 4'b0100;
        2'b11:   res = 4'b1000;
        default: res = 4'b0000;
      endcase
    end
    return res;
  endfunction

  logic       stage_en;
  logic [1:0] stage_sel;

`ifdef DECODER_2_TO_4_INPUT_REG_EN
  // Stage p0: optional input capture
  logic       en_p0_d, en_p0_q;
  logic [1:0] sel_p0_d, sel_p0_q;

  always_comb begin
    en_p0_d  = enable;
    sel_p0_d = in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_p0_q  <= 1'b0;
      sel_p0_q <= 2'b00;
    end else begin
      en_p0_q  <= en_p0_d;
      sel_p0_q <= sel_p0_d;
    end
  end

  always_comb begin
    stage_en  = en_p0_q;
    stage_sel = sel_p0_q;
  end
`else
  always_comb begin
    stage_en  = enable;
    stage_sel = in;
  end
`endif

  // Stage p1: decode register; polarity is folded in before the flop so out is a pure flop output
  logic [3:0] out_p1_d, out_p1_q;

  always_comb begin
    out_p1_d = decode(stage_en, stage_sel) ^ POL_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1_q <= POL_MASK;
    end else begin
      out_p1_q <= out_p1_d;
    end
  end

  assign out = out_p1_q;

endmodule

// File: tb/tb_decoder_2_to_4.sv
// Directed and random self-checking bench for decoder_2_to_4 (default build, 1-cycle latency),
// exercising both output polarities side by side.
module tb_decoder_2_to_4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] in;
  logic [3:0] out_hi;
  logic [3:0] out_lo;

  int passes;
  int total;

  decoder_2_to_4 #(.OUT_ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .out(out_hi)
  );

  decoder_2_to_4 #(.OUT_ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .out(out_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic cyc(input logic r, input logic en, input logic [1:0] s);
    rst    = r;
    enable = en;
    in     = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp;
    logic       r_rnd, en_rnd;
    logic [1:0] s_rnd;
    int         hot_exp;

    passes = 0;
    total  = 0;
    rst    = 1'b1;
    enable = 1'b0;
    in     = 2'b00;
    #2;

    // Reset held 2 cycles with enable=1, in=11
    cyc(1'b1, 1'b1, 2'b11); check("rst_c0_hi", out_hi, 4'b0000); check("rst_c0_lo", out_lo, 4'b1111);
    cyc(1'b1, 1'b1, 2'b11); check("rst_c1_hi", out_hi, 4'b0000); check("rst_c1_lo", out_lo, 4'b1111);
    cyc(1'b0, 1'b1, 2'b11); check("rst_rel_hi", out_hi, 4'b1000); check("rst_rel_lo", out_lo, 4'b0111);

    // Disabled sweep
    cyc(1'b0, 1'b0, 2'b00); check("dis_00", out_hi, 4'b0000);
    cyc(1'b0, 1'b0, 2'b01); check("dis_01", out_hi, 4'b0000);
    cyc(1'b0, 1'b0, 2'b10); check("dis_10", out_hi, 4'b0000);
    cyc(1'b0, 1'b0, 2'b11); check("dis_11", out_hi, 4'b0000); check("dis_11_lo", out_lo, 4'b1111);

    // Enabled sweep, asserted bit moves each edge
    cyc(1'b0, 1'b1, 2'b00); check("en_00", out_hi, 4'b0001);
    cyc(1'b0, 1'b1, 2'b01); check("en_01", out_hi, 4'b0010); check("en_01_lo", out_lo, 4'b1101);
    cyc(1'b0, 1'b1, 2'b10); check("en_10", out_hi, 4'b0100);
    cyc(1'b0, 1'b1, 2'b11); check("en_11", out_hi, 4'b1000);
    cyc(1'b0, 1'b1, 2'b00); check("en_wrap_00", out_hi, 4'b0001);

    // Mid-operation reset with in=10 held
    cyc(1'b0, 1'b1, 2'b10); check("mid_pre", out_hi, 4'b0100);
    cyc(1'b1, 1'b1, 2'b10); check("mid_rst_hi", out_hi, 4'b0000); check("mid_rst_lo", out_lo, 4'b1111);
    cyc(1'b0, 1'b1, 2'b10); check("mid_post", out_hi, 4'b0100);

    // One-cycle enable pulse
    cyc(1'b0, 1'b0, 2'b01); check("pulse_lead", out_hi, 4'b0000);
    cyc(1'b0, 1'b1, 2'b01); check("pulse_on_hi", out_hi, 4'b0010); check("pulse_on_lo", out_lo, 4'b1101);
    cyc(1'b0, 1'b0, 2'b01); check("pulse_off_hi", out_hi, 4'b0000); check("pulse_off_lo", out_lo, 4'b1111);

    // Random traffic against an independent reference
    for (int i = 0; i < 1000; i++) begin
      r_rnd  = ($urandom_range(0, 31) == 0);
      en_rnd = $urandom_range(0, 1) == 1;
      s_rnd  = 2'($urandom_range(0, 3));
      if (r_rnd || !en_rnd) begin
        exp     = 4'b0000;
        hot_exp = 0;
      end else begin
        exp     = 4'b0001 << s_rnd;
        hot_exp = 1;
      end
      cyc(r_rnd, en_rnd, s_rnd);
      check("rnd_hi", out_hi, exp);
      check("rnd_lo", out_lo, ~exp);
      total++;
      assert ($countones(out_hi) == hot_exp) passes++;
      else $error("FAIL rnd_hot: observed %0d hot bits expected %0d", $countones(out_hi), hot_exp);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
